bcd_adder8_ctrl: RTL
====================

Name: bcd_adder8_ctrl

Overview:
Sequencing controller for the DE1 8-bit BCD adder. It walks the user through entering operand A, operand B and carry-in from the slide switches, one debounced button press per step. It holds the operand and result registers, validates BCD input and the adder's result, and drives the 3-bit select of the display output mux. The BCD adder itself is combinational and sits outside this block, fed by a_reg/b_reg/cin_reg and returning adder_sum.

Parameters:
INIT_TICKS, 50_000_000, clk cycles the power-up "0000" display is held (1 s at 50 MHz); must be >= 1
ERR_TICKS, 100_000_000, clk cycles the "Err" display is held (2 s at 50 MHz); must be >= 1
CNT_W, 27, width of the shared tick counter; must hold max(INIT_TICKS, ERR_TICKS)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
btn_next  in  1  debounced "enter/next" button, level, active-high
btn_clr  in  1  debounced "clear" button, level, active-high
SW  in  10  slide switches; SW[7:0] = two BCD digits, SW[0] = carry-in
adder_sum  in  12  combinational BCD sum from the external adder: {hundreds, tens, ones}
a_reg  out  8  latched operand A (BCD)
b_reg  out  8  latched operand B (BCD)
cin_reg  out  1  latched carry-in
RSLT  out  12  latched result register
out_mux_sel  out  3  display select: 0 SHOWA, 1 SHOWB, 2 SHOWCIN, 3 SHOWRSLT, 4 SHOWZEROS, 5 SHOWBLNKS, 6 SHOWERR
rslt_valid  out  1  high only in state SHOW

Behaviour:
- Reset (synchronous, clk rising edge with reset=1):
  - state=INIT; a_reg, b_reg, cin_reg, RSLT, counter all 0.
  - next_prev=1 and clr_prev=1, so a button already held through reset does not register.
  - out_mux_sel=4; rslt_valid=0.
  - Reset overrides every other event and is honoured mid-sequence.
- Edge detect:
  - press = btn_next & ~next_prev; clear = btn_clr & ~clr_prev.
  - The prev flops update every cycle.
  - A held button yields exactly one press.
- out_mux_sel and rslt_valid are decoded combinationally from the state register. They change in the cycle after the edge that changes state.
- States (display code in parentheses):
  - INIT (4): counter counts up from 0. When counter==INIT_TICKS-1, go to GET_A and clear counter. Press and clear are ignored.
  - GET_A (0): on press:
    - If SW[7:4]<=9 and SW[3:0]<=9: a_reg<=SW[7:0] and go to GET_B.
    - Otherwise: go to ERR with ret=GET_A; a_reg is unchanged.
  - GET_B (1): on press, same as GET_A but loads b_reg; next state is GET_CIN, error ret=GET_B.
  - GET_CIN (2): on press, cin_reg<=SW[0] and go to CALC. SW[9:1] are ignored; no error is possible.
  - CALC (5): lasts exactly 1 cycle; adder_sum is sampled at its exit edge.
    - Valid iff adder_sum[11:9]==0, adder_sum[7:4]<=9 and adder_sum[3:0]<=9. Then RSLT<=adder_sum and go to SHOW.
    - Otherwise go to ERR with ret=GET_A; RSLT is unchanged.
    - Press is ignored in CALC.
  - SHOW (3): holds RSLT; on press, go to GET_A. Operands are kept so a new entry overwrites them.
  - ERR (6): counter counts up from 0. When counter==ERR_TICKS-1, go to ret and clear counter. Press is ignored.
- Clear (btn_clr edge) in any state other than INIT:
  - a_reg, b_reg, cin_reg and RSLT are set to 0; counter is set to 0; go to GET_A.
  - Clear wins over a press in the same cycle.
  - Clear during ERR aborts the error display.
- Latency:
  - Press in cycle k: the register load and state change occur at the end of k, and out_mux_sel shows the new code in k+1.
  - From the GET_CIN press to rslt_valid=1 is 2 cycles.
- Unused state encodings recover to INIT.

Test Plan:
(Sim overrides: INIT_TICKS=4, ERR_TICKS=3.)
1. Reset, then idle -> out_mux_sel=4 for exactly 4 cycles, then 0; all registers 0; rslt_valid=0.
2. SW=0x045, press; SW=0x038, press; SW=0x001, press -> a_reg=0x45, b_reg=0x38, cin_reg=1; out_mux_sel sequence 0,1,2,5,3; adder_sum=0x084 gives RSLT=0x084; rslt_valid=1 two cycles after the cin press.
3. In GET_A, SW=0x0A5, press -> out_mux_sel=6 for 3 cycles, then 0; a_reg remains 0.
4. After a valid A and B entry, drive adder_sum=0x1A0 in CALC -> ERR for 3 cycles, then GET_A; RSLT unchanged.
5. In GET_B, btn_next and btn_clr rise in the same cycle -> state GET_A, a_reg=0, b_reg=0; no b_reg load.
6. Hold btn_next high through reset deassertion and for 10 more cycles -> no advance beyond INIT/GET_A. Then assert reset while in SHOW -> out_mux_sel=4 and RSLT=0 the next cycle.

Source files
------------

// File: rtl/bcd_adder8_ctrl_if.sv
// Bus between the BCD-adder sequencing controller and its surroundings: operator inputs,
// the external adder's sum, and the latched operands/result/display select.
interface bcd_adder8_ctrl_if;
   logic        btn_next;
   logic        btn_clr;
   logic [9:0]  SW;
   logic [11:0] adder_sum;
   logic [7:0]  a_reg;
   logic [7:0]  b_reg;
   logic        cin_reg;
   logic [11:0] RSLT;
   logic [2:0]  out_mux_sel;
   logic        rslt_valid;

   modport master (
      output btn_next, btn_clr, SW, adder_sum,
      input  a_reg, b_reg, cin_reg, RSLT, out_mux_sel, rslt_valid
   );

   modport slave (
      input  btn_next, btn_clr, SW, adder_sum,
      output a_reg, b_reg, cin_reg, RSLT, out_mux_sel, rslt_valid
   );
endinterface

// File: rtl/bcd_adder8_ctrl.sv
// Sequencing controller for the DE1 8-bit BCD adder: steps through A, B and carry-in entry,
// validates BCD operands and the adder result, and selects what the display shows.
module bcd_adder8_ctrl #(
   parameter int unsigned INIT_TICKS = 50_000_000,
   parameter int unsigned ERR_TICKS  = 100_000_000,
   parameter int unsigned CNT_W      = 27
) (
   input logic              clk,
   input logic              reset,
   bcd_adder8_ctrl_if.slave ctrl_io
);

   // State encodings match the display code each state shows.
   localparam logic [2:0] StGetA   = 3'd0;
   localparam logic [2:0] StGetB   = 3'd1;
   localparam logic [2:0] StGetCin = 3'd2;
   localparam logic [2:0] StShow   = 3'd3;
   localparam logic [2:0] StInit   = 3'd4;
   localparam logic [2:0] StCalc   = 3'd5;
   localparam logic [2:0] StErr    = 3'd6;

   localparam logic [CNT_W-1:0] InitLast = CNT_W'(INIT_TICKS - 1);
   localparam logic [CNT_W-1:0] ErrLast  = CNT_W'(ERR_TICKS - 1);

   logic [2:0]       state_q, state_d;
   logic [2:0]       ret_q, ret_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic             cin_q, cin_d;
   logic [11:0]      rslt_q, rslt_d;
   logic             next_prev_q;
   logic             clr_prev_q;

   logic press;
   logic clear;
   logic sw_bcd_ok;
   logic sum_ok;
   logic unused_sw;

   assign press     = ctrl_io.btn_next & ~next_prev_q;
   assign clear     = ctrl_io.btn_clr & ~clr_prev_q;
   assign sw_bcd_ok = (ctrl_io.SW[7:4] <= 4'd9) && (ctrl_io.SW[3:0] <= 4'd9);
   assign sum_ok    = (ctrl_io.adder_sum[11:9] == 3'b000) &&
                      (ctrl_io.adder_sum[7:4] <= 4'd9) && (ctrl_io.adder_sum[3:0] <= 4'd9);
   assign unused_sw = ^ctrl_io.SW[9:8];

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      rslt_d  = rslt_q;

      if (clear && state_q != StInit) begin
         // Clear beats a simultaneous press and aborts an error display.
         state_d = StGetA;
         cnt_d   = '0;
         a_d     = '0;
         b_d     = '0;
         cin_d   = 1'b0;
         rslt_d  = '0;
      end else begin
         case (state_q)
            StInit: begin
               if (cnt_q == InitLast) begin
                  state_d = StGetA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StGetA: begin
               if (press) begin
                  if (sw_bcd_ok) begin
                     a_d     = ctrl_io.SW[7:0];
                     state_d = StGetB;
                  end else begin
                     state_d = StErr;
                     ret_d   = StGetA;
                     cnt_d   = '0;
                  end
               end
            end
            StGetB: begin
               if (press) begin
                  if (sw_bcd_ok) begin
                     b_d     = ctrl_io.SW[7:0];
                     state_d = StGetCin;
                  end else begin
                     state_d = StErr;
                     ret_d   = StGetB;
                     cnt_d   = '0;
                  end
               end
            end
            StGetCin: begin
               if (press) begin
                  cin_d   = ctrl_io.SW[0];
                  state_d = StCalc;
               end
            end
            StCalc: begin
               // One cycle for the external adder to settle on the new operands.
               if (sum_ok) begin
                  rslt_d  = ctrl_io.adder_sum;
                  state_d = StShow;
               end else begin
                  state_d = StErr;
                  ret_d   = StGetA;
                  cnt_d   = '0;
               end
            end
            StShow: begin
               if (press) state_d = StGetA;
            end
            StErr: begin
               if (cnt_q == ErrLast) begin
                  state_d = ret_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StInit;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInit;
         ret_q       <= StGetA;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         rslt_q      <= '0;
         next_prev_q <= 1'b1;
         clr_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cin_q       <= cin_d;
         rslt_q      <= rslt_d;
         next_prev_q <= ctrl_io.btn_next;
         clr_prev_q  <= ctrl_io.btn_clr;
      end
   end

   always_comb begin
      ctrl_io.out_mux_sel = 3'd4;
      ctrl_io.rslt_valid  = 1'b0;
      case (state_q)
         StGetA:   ctrl_io.out_mux_sel = 3'd0;
         StGetB:   ctrl_io.out_mux_sel = 3'd1;
         StGetCin: ctrl_io.out_mux_sel = 3'd2;
         StShow: begin
            ctrl_io.out_mux_sel = 3'd3;
            ctrl_io.rslt_valid  = 1'b1;
         end
         StCalc:   ctrl_io.out_mux_sel = 3'd5;
         StErr:    ctrl_io.out_mux_sel = 3'd6;
         default:  ctrl_io.out_mux_sel = 3'd4;
      endcase
   end

   assign ctrl_io.a_reg   = a_q;
   assign ctrl_io.b_reg   = b_q;
   assign ctrl_io.cin_reg = cin_q;
   assign ctrl_io.RSLT    = rslt_q;

endmodule
